// File: rtl/alu_seq_module.sv
// Multi-cycle ALU: operand latches, registered result/flags, iterative shifts and,
// when ALU_MUL_EN is defined, an iterative shift-add multiplier.
module alu_seq_module #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] A_bus,
  input  logic             Sa,
  input  logic             Sb,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             ALS,
  output logic [WIDTH-1:0] ALU_out,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CNT_W = SHW + 1;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOTA  = 4'd7;
  localparam logic [3:0] OP_INCA  = 4'd8;
  localparam logic [3:0] OP_DECA  = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_SAR   = 4'd12;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd13;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_MUL = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_e;
`endif

  // Handshake: start is accepted only in ST_IDLE (it is dropped otherwise, never
  // queued); busy is high while an iterative op runs; done pulses for exactly one
  // cycle after the edge that writes result and flags (also for reserved opcodes).
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [3:0]         sop_q, sop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nx;
`endif

  logic [WIDTH-1:0] one_w;
  logic [WIDTH-1:0] add_rhs, sub_rhs;
  logic [WIDTH:0]   add_w, sub_w;
  logic             add_ovf, sub_ovf;
  logic [SHW-1:0]   sh_n;
  logic             is_shift;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_valid;
  logic [WIDTH-1:0] sh_nx;
  logic             sh_out;
  logic             wr;

  // Operand latches; a running op works on its own snapshot, so loads are free.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (Sa) a_q <= A_bus;
      if (Sb) b_q <= A_bus;
    end
  end

  assign one_w    = {{(WIDTH-1){1'b0}}, 1'b1};
  assign add_rhs  = (op == OP_INCA) ? one_w : b_q;
  assign sub_rhs  = (op == OP_DECA) ? one_w : b_q;
  assign add_w    = {1'b0, a_q} + {1'b0, add_rhs};
  assign sub_w    = {1'b0, a_q} - {1'b0, sub_rhs};
  assign add_ovf  = (a_q[WIDTH-1] == add_rhs[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf  = (a_q[WIDTH-1] != sub_rhs[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
  assign sh_n     = b_q[SHW-1:0];
  assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);

  always_comb begin
    sc_res   = a_q;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_valid = 1'b1;
    case (op)
      OP_PASSA:         sc_res = a_q;
      OP_PASSB:         sc_res = b_q;
      OP_ADD, OP_INCA: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = add_ovf;
      end
      OP_SUB, OP_DECA: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = sub_ovf;
      end
      OP_AND:           sc_res = a_q & b_q;
      OP_OR:            sc_res = a_q | b_q;
      OP_XOR:           sc_res = a_q ^ b_q;
      OP_NOTA:          sc_res = ~a_q;
      // Only reached with a zero shift amount: result is A, carry stays 0.
      OP_SHL, OP_SHR, OP_SAR: sc_res = a_q;
      default:          sc_valid = 1'b0;
    endcase
  end

  always_comb begin
    sh_nx  = sh_q;
    sh_out = 1'b0;
    case (sop_q)
      OP_SHL: begin
        sh_nx  = {sh_q[WIDTH-2:0], 1'b0};
        sh_out = sh_q[WIDTH-1];
      end
      OP_SHR: begin
        sh_nx  = {1'b0, sh_q[WIDTH-1:1]};
        sh_out = sh_q[0];
      end
      default: begin
        sh_nx  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        sh_out = sh_q[0];
      end
    endcase
  end

`ifdef ALU_MUL_EN
  // Classic right-shifting multiplier: high half accumulates, low half holds B.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign prod_nx = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                             : {1'b0, prod_q[2*WIDTH-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    sh_d    = sh_q;
    sop_d   = sop_q;
    cnt_d   = cnt_q;
`ifdef ALU_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
`endif
    wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift && (sh_n != '0)) begin
            state_d = ST_SHIFT;
            sh_d    = a_q;
            sop_d   = op;
            cnt_d   = {1'b0, sh_n};
`ifdef ALU_MUL_EN
          end else if (op == OP_MUL) begin
            state_d = ST_MUL;
            prod_d  = {{WIDTH{1'b0}}, b_q};
            mcand_d = a_q;
            cnt_d   = CNT_W'(WIDTH);
`endif
          end else if (sc_valid) begin
            res_d   = sc_res;
            carry_d = sc_c;
            ovf_d   = sc_v;
            wr      = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          res_d   = sh_nx;
          carry_d = sh_out;
          ovf_d   = 1'b0;
          wr      = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          res_d   = prod_nx[WIDTH-1:0];
          carry_d = 1'b0;
          ovf_d   = |prod_nx[2*WIDTH-1:WIDTH];
          wr      = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (wr) begin
      zero_d = (res_d == '0);
      neg_d  = res_d[WIDTH-1];
      done_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      sh_q    <= '0;
      sop_q   <= '0;
      cnt_q   <= '0;
`ifdef ALU_MUL_EN
      prod_q  <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      sh_q    <= sh_d;
      sop_q   <= sop_d;
      cnt_q   <= cnt_d;
`ifdef ALU_MUL_EN
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  assign ALU_out  = res_q & {WIDTH{ALS}};
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule
